// File: rtl/key_entry_buffer_if.sv
// Key entry bus: debounced key levels in, entered digits and event pulses out.
interface key_entry_buffer_if;
    logic [15:0] key_deb;
    logic [15:0] digits;
    logic [2:0]  count;
    logic [3:0]  key_code;
    logic        key_stb;
    logic        multi_err;
    logic        ovf;

    modport master (
        output key_deb,
        input  digits, count, key_code, key_stb, multi_err, ovf
    );

    modport slave (
        input  key_deb,
        output digits, count, key_code, key_stb, multi_err, ovf
    );
endinterface

// File: rtl/key_entry_buffer.sv
// Keypad entry buffer: accepts one key per press/release cycle, shifts hex
// digits into a four-digit register, handles backspace (key 14) and clear
// (key 15), and rejects presses with more than one key down.
//
// state   | meaning
// IDLE    | released long enough, next nonzero sample is a new press
// HELD    | a press is in progress, pattern changes are ignored
// RELEASE | all keys up, counting quiet cycles before re-arming
module key_entry_buffer #(
    parameter int REL_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    key_entry_buffer_if.slave bus
);

    localparam int CW = (REL_CYCLES > 2) ? $clog2(REL_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   rel_cnt_q;
    logic [15:0]     digits_q, digits_d;
    logic [2:0]      count_q, count_d;
    logic [3:0]      key_code_q;
    logic            key_stb_q;
    logic            multi_err_q;
    logic            ovf_q, ovf_d;
    logic [3:0]      key_idx;
    logic            key_any;
    logic            key_one_hot;

    assign key_any     = (bus.key_deb != 16'h0000);
    assign key_one_hot = key_any && ((bus.key_deb & (bus.key_deb - 16'h0001)) == 16'h0000);

    // Key index and the digit-register result of applying that key; only
    // loaded when a one-hot press is accepted, so multi-bit garbage is harmless.
    always_comb begin
        key_idx  = 4'h0;
        digits_d = digits_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        for (int i = 0; i < 16; i++) begin
            if (bus.key_deb[i]) key_idx = 4'(i);
        end
        case (key_idx)
            4'd15: begin
                digits_d = 16'h0000;
                count_d  = 3'd0;
                ovf_d    = 1'b0;
            end
            4'd14: begin
                if (count_q != 3'd0) begin
                    digits_d = {4'h0, digits_q[15:4]};
                    count_d  = count_q - 3'd1;
                end
            end
            default: begin
                digits_d = {digits_q[11:0], key_idx};
                if (count_q == 3'd4) ovf_d = 1'b1;
                else                 count_d = count_q + 3'd1;
            end
        endcase
    end

    // Press/release FSM with registered outputs; reset parks in RELEASE so a
    // key held through reset must be fully released before it counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RELEASE;
            rel_cnt_q   <= '0;
            digits_q    <= 16'h0000;
            count_q     <= 3'd0;
            key_code_q  <= 4'h0;
            key_stb_q   <= 1'b0;
            multi_err_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            key_stb_q   <= 1'b0;
            multi_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_any) begin
                        state_q <= HELD;
                        if (key_one_hot) begin
                            key_stb_q  <= 1'b1;
                            key_code_q <= key_idx;
                            digits_q   <= digits_d;
                            count_q    <= count_d;
                            ovf_q      <= ovf_d;
                        end else begin
                            multi_err_q <= 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!key_any) begin
                        state_q   <= RELEASE;
                        rel_cnt_q <= '0;
                    end
                end
                RELEASE: begin
                    if (key_any) begin
                        state_q <= HELD;
                    end else begin
                        rel_cnt_q <= rel_cnt_q + 1'b1;
                        if (rel_cnt_q == CW'(REL_CYCLES - 2)) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.digits    = digits_q;
    assign bus.count     = count_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_stb   = key_stb_q;
    assign bus.multi_err = multi_err_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Bench for key_entry_buffer: directed scenarios plus random key traffic,
// compared every cycle against a queue-based model of the entry rules.
module tb_key_entry_buffer;

    localparam int REL = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_entry_buffer_if bus ();

    key_entry_buffer #(.REL_CYCLES(REL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int stb_cnt    = 0;
    int merr_cnt   = 0;
    bit check_en   = 1'b0;

    // Model state: digits as a queue (front oldest), plus quiet-sample count.
    logic [3:0]  mq[$];
    int          zeros = 0;
    logic [15:0] e_digits = 16'h0;
    logic [2:0]  e_count = 3'd0;
    logic [3:0]  e_code = 4'h0;
    logic        e_stb = 1'b0;
    logic        e_merr = 1'b0;
    logic        e_ovf = 1'b0;

    // Model update on each rising edge from the inputs sampled there.
    always @(posedge clk) begin
        logic [15:0] k;
        int idx;
        k = bus.key_deb;
        if (rst) begin
            mq.delete();
            e_code   = 4'h0;
            e_stb    = 1'b0;
            e_merr   = 1'b0;
            e_ovf    = 1'b0;
            zeros    = 1;
            check_en = 1'b1;
        end else begin
            e_stb  = 1'b0;
            e_merr = 1'b0;
            if (k != 16'h0) begin
                if (zeros >= REL) begin
                    if ($countones(k) == 1) begin
                        idx = 0;
                        for (int j = 0; j < 16; j++) if (k[j]) idx = j;
                        e_stb  = 1'b1;
                        e_code = 4'(idx);
                        if (idx <= 13) begin
                            mq.push_back(4'(idx));
                            if (mq.size() > 4) begin
                                void'(mq.pop_front());
                                e_ovf = 1'b1;
                            end
                        end else if (idx == 14) begin
                            if (mq.size() > 0) void'(mq.pop_back());
                        end else begin
                            mq.delete();
                            e_ovf = 1'b0;
                        end
                    end else begin
                        e_merr = 1'b1;
                    end
                end
                zeros = 0;
            end else if (zeros < REL) begin
                zeros++;
            end
        end
        e_digits = 16'h0;
        for (int j = 0; j < mq.size(); j++) e_digits = {e_digits[11:0], mq[j]};
        e_count = 3'(mq.size());
    end

    // Per-cycle compare of every output against the model, mid-cycle.
    always @(negedge clk) begin
        if (check_en) begin
            vectors++;
            if (bus.key_stb)   stb_cnt++;
            if (bus.multi_err) merr_cnt++;
            if ({bus.digits, bus.count, bus.key_code, bus.key_stb, bus.multi_err, bus.ovf} !==
                {e_digits, e_count, e_code, e_stb, e_merr, e_ovf}) begin
                miscompares++;
                $display("FAIL cycle_cmp t=%0t got digits=%h count=%0d code=%0d stb=%b merr=%b ovf=%b want digits=%h count=%0d code=%0d stb=%b merr=%b ovf=%b",
                         $time, bus.digits, bus.count, bus.key_code, bus.key_stb, bus.multi_err, bus.ovf,
                         e_digits, e_count, e_code, e_stb, e_merr, e_ovf);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic drive(input logic [15:0] k, input logic r, input int n);
        repeat (n) begin
            @(negedge clk);
            bus.key_deb = k;
            rst = r;
        end
    endtask

    task automatic press(input int key);
        drive(16'h1 << key, 1'b0, 3);
        drive(16'h0, 1'b0, REL);
    endtask

    int sb, mb;
    logic [15:0] k;
    int a, b, r;

    initial begin
        bus.key_deb = 16'h0;
        rst = 1'b1;
        drive(16'h0, 1'b1, 2);
        drive(16'h0, 1'b0, REL);
        #1;
        chk("reset_digits", bus.digits, 16'h0);
        chk("reset_count", 16'(bus.count), 16'h0);
        chk("reset_flags", 16'({bus.key_code, bus.key_stb, bus.multi_err, bus.ovf}), 16'h0);

        // Two digits
        sb = stb_cnt;
        press(3);
        press(7);
        #1;
        chk("two_digits", bus.digits, 16'h0037);
        chk("two_count", 16'(bus.count), 16'd2);
        chk("two_code", 16'(bus.key_code), 16'd7);
        chk("two_stb", 16'(stb_cnt - sb), 16'd2);

        // Overflow then clear
        press(15);
        for (int i = 1; i <= 5; i++) press(i);
        #1;
        chk("ovf_digits", bus.digits, 16'h2345);
        chk("ovf_count", 16'(bus.count), 16'd4);
        chk("ovf_flag", 16'(bus.ovf), 16'd1);
        press(15);
        #1;
        chk("clr_state", {bus.digits[11:0], 1'b0, bus.count}, 16'h0);
        chk("clr_ovf", 16'(bus.ovf), 16'd0);

        // Backspace down to empty and once more
        press(1); press(2); press(3);
        #1;
        chk("bs_start", bus.digits, 16'h0123);
        press(14); press(14); press(14);
        #1;
        chk("bs3_digits", bus.digits, 16'h0);
        chk("bs3_count", 16'(bus.count), 16'd0);
        sb = stb_cnt;
        press(14);
        #1;
        chk("bs4_digits", bus.digits, 16'h0);
        chk("bs4_stb", 16'(stb_cnt - sb), 16'd1);

        // Multi-key rejection, then pattern change without release
        press(6);
        sb = stb_cnt;
        mb = merr_cnt;
        drive(16'h0011, 1'b0, 2);
        drive(16'h0010, 1'b0, 3);
        drive(16'h0, 1'b0, REL);
        #1;
        chk("multi_merr", 16'(merr_cnt - mb), 16'd1);
        chk("multi_stb", 16'(stb_cnt - sb), 16'd0);
        chk("multi_digits", bus.digits, 16'h0006);

        // Short release bounce is one press
        sb = stb_cnt;
        drive(16'h0020, 1'b0, 3);
        drive(16'h0, 1'b0, 10);
        drive(16'h0020, 1'b0, 3);
        drive(16'h0, 1'b0, REL);
        #1;
        chk("bounce_stb", 16'(stb_cnt - sb), 16'd1);
        chk("bounce_digits", bus.digits, 16'h0065);

        // Key held through reset
        sb = stb_cnt;
        drive(16'h0200, 1'b1, 2);
        drive(16'h0200, 1'b0, 50);
        drive(16'h0, 1'b0, REL);
        #1;
        chk("hold_rst_stb", 16'(stb_cnt - sb), 16'd0);
        press(9);
        #1;
        chk("hold_rst_new_stb", 16'(stb_cnt - sb), 16'd1);
        chk("hold_rst_digits", bus.digits, 16'h0009);

        // Random traffic
        for (int s = 0; s < 300; s++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                drive(16'($urandom), 1'b1, $urandom_range(1, 2));
            end else begin
                r = $urandom_range(0, 99);
                if (r < 75) begin
                    a = $urandom_range(0, 15);
                    if (a == 15 && $urandom_range(0, 1) == 1) a = $urandom_range(0, 13);
                    k = 16'h1 << a;
                end else if (r < 88) begin
                    a = $urandom_range(0, 15);
                    b = (a + $urandom_range(1, 15)) % 16;
                    k = (16'h1 << a) | (16'h1 << b);
                end else begin
                    k = 16'($urandom);
                end
                drive(k, 1'b0, $urandom_range(1, 4));
                if ($urandom_range(0, 3) == 0)
                    drive(k ^ (16'h1 << $urandom_range(0, 15)), 1'b0, $urandom_range(1, 3));
                if ($urandom_range(0, 3) == 0)
                    drive(16'h0, 1'b0, $urandom_range(0, 15));
                else
                    drive(16'h0, 1'b0, $urandom_range(15, 20));
            end
        end
        drive(16'h0, 1'b0, 4);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_entry_buffer.md
KEY_ENTRY_BUFFER -- requirements
Module: key_entry_buffer

Interface
REQ-001 SHALL have parameter REL_CYCLES, default 16, the number of consecutive all-zero key_deb cycles required to accept a release (range 2..65535).
REQ-002 SHALL have port clk  input  1  the single system clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port key_deb  input  16  debounced key levels; bit i high means key i is held; at most one bit is expected high.
REQ-005 SHALL have port digits  output  16  four entered hex digits; [3:0] is the newest digit and [15:12] the oldest.
REQ-006 SHALL have port count  output  3  the number of valid digits, 0..4.
REQ-007 SHALL have port key_code  output  4  the binary index of the last accepted key.
REQ-008 SHALL have port key_stb  output  1  a one-cycle pulse for each accepted key press.
REQ-009 SHALL have port multi_err  output  1  a one-cycle pulse when a press with more than one bit set is rejected.
REQ-010 SHALL have port ovf  output  1  sticky flag: a digit was shifted out of [15:12].

Function
REQ-011 SHALL implement an FSM with three states, IDLE, HELD and RELEASE, plus a release counter of width ceil(log2(REL_CYCLES)).
REQ-012 In IDLE with key_deb == 0, the FSM SHALL stay in IDLE and all pulses SHALL be 0.
REQ-013 In IDLE with key_deb exactly one-hot (bit i), the FSM SHALL go to HELD, and on the next edge SHALL set key_code=i, pulse key_stb for one cycle and apply the action of key i, giving a latency of 1 cycle.
REQ-014 In IDLE with key_deb nonzero and not one-hot, the FSM SHALL go to HELD, pulse multi_err for one cycle, and leave digits, count, key_code and ovf unchanged.
REQ-015 In HELD, the FSM SHALL stay while key_deb != 0; changes of the held pattern SHALL be ignored and SHALL produce no event; when key_deb == 0 it SHALL go to RELEASE with counter=0.
REQ-016 In RELEASE with key_deb != 0, the FSM SHALL return to HELD with no event.
REQ-017 In RELEASE with key_deb == 0, the counter SHALL increment, and when the counter reaches REL_CYCLES-1 the FSM SHALL enter IDLE on that edge.
REQ-018 From the last nonzero sample, at least REL_CYCLES+1 cycles SHALL elapse before a new press can be accepted.
REQ-019 For keys 0..13 (digit entry), the block SHALL set digits <= {digits[11:0], i[3:0]} and count <= min(count+1, 4).
REQ-020 If a digit is entered while count==4, the old digits[15:12] SHALL be discarded and ovf SHALL be set to 1.
REQ-021 For key 14 (backspace), when count>0 the block SHALL set digits <= {4'h0, digits[15:4]} and count <= count-1.
REQ-022 For key 14 (backspace) with count==0, digits and count SHALL be unchanged; key_stb SHALL still pulse.
REQ-023 For key 15 (clear), the block SHALL set digits=0, count=0 and ovf=0, and key_stb SHALL pulse.
REQ-024 key_stb and multi_err SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per event.
REQ-025 All outputs SHALL be registered, with no combinational path from key_deb to any output.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL set digits=0, count=0, key_code=0, key_stb=0, multi_err=0 and ovf=0.
REQ-027 When rst=1 at a clock edge, the FSM SHALL enter RELEASE with counter=0, so a key held through reset is not accepted until it is released for REL_CYCLES cycles.
REQ-028 rst SHALL have priority over every other input, including an event in the same cycle; reset in HELD or RELEASE SHALL abort the operation with no pulse.

Verification
REQ-029 Press key 3, release for 16 cycles, then press key 7 -> key_stb pulses twice, each one cycle after its press; digits=16'h0037, count=2, key_code=7.
REQ-030 Enter keys 1,2,3,4,5 (each with a full release) -> digits=16'h2345, count=4, ovf=1; then key 15 -> digits=0, count=0, ovf=0.
REQ-031 From digits=16'h0123, count=3, press key 14 three times then a fourth time -> after three presses digits=0, count=0; the fourth press gives digits=0, count=0 and a key_stb pulse.
REQ-032 Apply key_deb=16'h0011 in IDLE -> multi_err pulses once, key_stb=0, digits unchanged; then key_deb=16'h0010 without release -> no event.
REQ-033 Press key 5, drop key_deb to 0 for 10 cycles (<16), re-assert key 5, then release for 16 cycles -> exactly one key_stb pulse.
REQ-034 Hold key 9 while rst is asserted and deasserted, keep it held for 50 more cycles, release for 16 cycles, then press key 9 -> no event during the hold; one event on the new press with digits=16'h0009.
